xbar_internal_switch: RTL and testbench



---
 rtl/xbar_internal_switch.sv | 169 ++++++++++++++++
 tb/tb_xbar_internal_switch.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/xbar_internal_switch.sv
// xbar_internal_switch
//   Internal switching stage of a 5-port (N,S,E,W,PE) mesh router.
//   Each input's head packet is routed with XY dimension-order routing
//   (X first, then Y, then eject to PE). The result is a per-output request
//   vector and a hop-updated packet. When an external arbiter grants an
//   input to an output during the internal phase, the hop-updated packet
//   moves to that output buffer. The move is signalled one clock later by
//   enq/d_in on the output side and deq on the input side.
//
//   Vector index order for every 5-bit request/grant: N=4, S=3, E=2, W=1, PE=0.
//
// Ports
//   clk, reset                  clock, synchronous active-high reset
//   phase_internal              transfer phase enable
//   {n,s,e,w,pe}_full/_q        input buffer valid flag and head packet
//   gnt_to_{n,s,e,w,pe}         one-hot grant per output
//   outbuf_full_{n,s,e,w,pe}    output buffer back-pressure
//   req_to_*, *_pkt_next        combinational request vectors and next packets
//   enq_*, d_in_*, deq_*        registered transfer strobes and data

// Per-input XY route computation.
module xbar_route (
    input  logic        full,
    input  logic [63:0] pkt,
    output logic [4:0]  req,
    output logic [63:0] pkt_next
);
    logic [3:0] hx, hy;
    logic [4:0] dest;

    assign hx = pkt[55:52];
    assign hy = pkt[51:48];

    always_comb begin
        dest     = 5'b00001;
        pkt_next = pkt;
        if (hx != 4'd0) begin
            dest              = pkt[62] ? 5'b00010 : 5'b00100;
            pkt_next[55:52]   = hx - 4'd1;
        end else if (hy != 4'd0) begin
            dest              = pkt[61] ? 5'b01000 : 5'b10000;
            pkt_next[51:48]   = hy - 4'd1;
        end
    end

    assign req = full ? dest : 5'b00000;
endmodule

module xbar_internal_switch (
    input  logic        clk,
    input  logic        reset,
    input  logic        phase_internal,
    input  logic        n_full,
    input  logic        s_full,
    input  logic        e_full,
    input  logic        w_full,
    input  logic        pe_full,
    input  logic [63:0] n_q,
    input  logic [63:0] s_q,
    input  logic [63:0] e_q,
    input  logic [63:0] w_q,
    input  logic [63:0] pe_q,
    input  logic [4:0]  gnt_to_n,
    input  logic [4:0]  gnt_to_s,
    input  logic [4:0]  gnt_to_e,
    input  logic [4:0]  gnt_to_w,
    input  logic [4:0]  gnt_to_pe,
    input  logic        outbuf_full_n,
    input  logic        outbuf_full_s,
    input  logic        outbuf_full_e,
    input  logic        outbuf_full_w,
    input  logic        outbuf_full_pe,
    output logic [4:0]  req_to_n,
    output logic [4:0]  req_to_s,
    output logic [4:0]  req_to_e,
    output logic [4:0]  req_to_w,
    output logic [4:0]  req_to_pe,
    output logic [63:0] n_pkt_next,
    output logic [63:0] s_pkt_next,
    output logic [63:0] e_pkt_next,
    output logic [63:0] w_pkt_next,
    output logic [63:0] pe_pkt_next,
    output logic        enq_n,
    output logic        enq_s,
    output logic        enq_e,
    output logic        enq_w,
    output logic        enq_pe,
    output logic [63:0] d_in_n,
    output logic [63:0] d_in_s,
    output logic [63:0] d_in_e,
    output logic [63:0] d_in_w,
    output logic [63:0] d_in_pe,
    output logic        deq_n,
    output logic        deq_s,
    output logic        deq_e,
    output logic        deq_w,
    output logic        deq_pe
);
    localparam int NUM_PORTS = 5;

    logic [NUM_PORTS-1:0]             full, obuf_full;
    logic [NUM_PORTS-1:0][63:0]       q, nxt, sel_pkt;
    logic [NUM_PORTS-1:0][NUM_PORTS-1:0] in_req;   // [input][output]
    logic [NUM_PORTS-1:0][NUM_PORTS-1:0] out_req;  // [output][input]
    logic [NUM_PORTS-1:0][NUM_PORTS-1:0] gnt;      // [output][input]
    logic [NUM_PORTS-1:0]             xfer, deq_nxt;
    logic [NUM_PORTS-1:0]             enq_r, deq_r;
    logic [NUM_PORTS-1:0][63:0]       d_in_r;

    assign full      = {n_full, s_full, e_full, w_full, pe_full};
    assign q         = {n_q, s_q, e_q, w_q, pe_q};
    assign gnt       = {gnt_to_n, gnt_to_s, gnt_to_e, gnt_to_w, gnt_to_pe};
    assign obuf_full = {outbuf_full_n, outbuf_full_s, outbuf_full_e,
                        outbuf_full_w, outbuf_full_pe};

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_route
        xbar_route u_route (
            .full     (full[i]),
            .pkt      (q[i]),
            .req      (in_req[i]),
            .pkt_next (nxt[i])
        );
    end

    always_comb begin
        out_req = '0;
        for (int o = 0; o < NUM_PORTS; o++)
            for (int i = 0; i < NUM_PORTS; i++)
                out_req[o][i] = in_req[i][o];
    end

    // With a one-hot grant, any overlap with the request vector means the
    // granted input is requesting; the AND-OR mux then picks its packet.
    always_comb begin
        xfer    = '0;
        deq_nxt = '0;
        sel_pkt = '0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            xfer[o] = phase_internal && !obuf_full[o] && (gnt[o] != '0) &&
                      ((gnt[o] & (gnt[o] - 5'd1)) == '0) &&
                      ((gnt[o] & out_req[o]) != '0);
            for (int i = 0; i < NUM_PORTS; i++)
                if (gnt[o][i])
                    sel_pkt[o] = sel_pkt[o] | nxt[i];
            // An input requests one output only, so it cannot dequeue twice.
            if (xfer[o])
                deq_nxt = deq_nxt | gnt[o];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            enq_r  <= '0;
            deq_r  <= '0;
            d_in_r <= '0;
        end else begin
            enq_r <= xfer;
            deq_r <= deq_nxt;
            for (int o = 0; o < NUM_PORTS; o++)
                d_in_r[o] <= xfer[o] ? sel_pkt[o] : 64'd0;
        end
    end

    assign {req_to_n, req_to_s, req_to_e, req_to_w, req_to_pe} = out_req;
    assign {n_pkt_next, s_pkt_next, e_pkt_next, w_pkt_next, pe_pkt_next} = nxt;
    assign {enq_n, enq_s, enq_e, enq_w, enq_pe} = enq_r;
    assign {deq_n, deq_s, deq_e, deq_w, deq_pe} = deq_r;
    assign {d_in_n, d_in_s, d_in_e, d_in_w, d_in_pe} = d_in_r;
endmodule

// File: tb/tb_xbar_internal_switch.sv
// Testbench for xbar_internal_switch: directed steps from the test plan
// followed by randomized cycles, checked against a routing model.
module tb_xbar_internal_switch;
    logic clk = 1'b0;
    logic reset, phase;
    logic [4:0]       full, obf;
    logic [4:0][63:0] q;
    logic [4:0][4:0]  gnt;
    logic [4:0][4:0]  req_to;
    logic [4:0][63:0] pkt_next, d_in;
    logic [4:0]       enq, deq;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    xbar_internal_switch dut (
        .clk(clk), .reset(reset), .phase_internal(phase),
        .n_full(full[4]), .s_full(full[3]), .e_full(full[2]), .w_full(full[1]), .pe_full(full[0]),
        .n_q(q[4]), .s_q(q[3]), .e_q(q[2]), .w_q(q[1]), .pe_q(q[0]),
        .gnt_to_n(gnt[4]), .gnt_to_s(gnt[3]), .gnt_to_e(gnt[2]), .gnt_to_w(gnt[1]), .gnt_to_pe(gnt[0]),
        .outbuf_full_n(obf[4]), .outbuf_full_s(obf[3]), .outbuf_full_e(obf[2]),
        .outbuf_full_w(obf[1]), .outbuf_full_pe(obf[0]),
        .req_to_n(req_to[4]), .req_to_s(req_to[3]), .req_to_e(req_to[2]),
        .req_to_w(req_to[1]), .req_to_pe(req_to[0]),
        .n_pkt_next(pkt_next[4]), .s_pkt_next(pkt_next[3]), .e_pkt_next(pkt_next[2]),
        .w_pkt_next(pkt_next[1]), .pe_pkt_next(pkt_next[0]),
        .enq_n(enq[4]), .enq_s(enq[3]), .enq_e(enq[2]), .enq_w(enq[1]), .enq_pe(enq[0]),
        .d_in_n(d_in[4]), .d_in_s(d_in[3]), .d_in_e(d_in[2]), .d_in_w(d_in[1]), .d_in_pe(d_in[0]),
        .deq_n(deq[4]), .deq_s(deq[3]), .deq_e(deq[2]), .deq_w(deq[1]), .deq_pe(deq[0])
    );

    // Reference: output port index reached by a packet (N=4,S=3,E=2,W=1,PE=0).
    function automatic int dest_of(input logic [63:0] p);
        if (p[55:52] != 0) return p[62] ? 1 : 2;
        if (p[51:48] != 0) return p[61] ? 3 : 4;
        return 0;
    endfunction

    function automatic logic [63:0] hop(input logic [63:0] p);
        if (p[55:52] != 0) return p - (64'd1 << 52);
        if (p[51:48] != 0) return p - (64'd1 << 48);
        return p;
    endfunction

    function automatic logic [63:0] mkpkt(input logic dx, input logic dy,
                                          input int hx, input int hy,
                                          input logic [31:0] pay);
        logic [63:0] p;
        p = 64'd0;
        p[62] = dx; p[61] = dy;
        p[55:52] = 4'(hx); p[51:48] = 4'(hy);
        p[47:40] = 8'h12; p[39:32] = 8'h34;
        p[31:0] = pay;
        return p;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Apply the current inputs for one clock; checks combinational outputs,
    // then the registered outputs produced by this edge.
    task automatic step(input logic rst);
        logic [4:0]       e_enq, e_deq;
        logic [4:0][63:0] e_din;
        logic [4:0]       e_req;
        int src;
        reset = rst;
        #1;
        for (int i = 0; i < 5; i++)
            chk($sformatf("pkt_next[%0d]", i), pkt_next[i], hop(q[i]));
        for (int o = 0; o < 5; o++) begin
            e_req = '0;
            for (int i = 0; i < 5; i++)
                if (full[i] && dest_of(q[i]) == o) e_req[i] = 1'b1;
            chk($sformatf("req_to[%0d]", o), 64'(req_to[o]), 64'(e_req));
        end
        e_enq = '0; e_deq = '0; e_din = '0;
        for (int o = 0; o < 5; o++) begin
            if (!rst && phase && !obf[o] && $countones(gnt[o]) == 1) begin
                src = 0;
                for (int i = 0; i < 5; i++) if (gnt[o][i]) src = i;
                if (full[src] && dest_of(q[src]) == o) begin
                    e_enq[o] = 1'b1;
                    e_din[o] = hop(q[src]);
                    e_deq[src] = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        chk("enq", 64'(enq), 64'(e_enq));
        chk("deq", 64'(deq), 64'(e_deq));
        for (int o = 0; o < 5; o++)
            chk($sformatf("d_in[%0d]", o), d_in[o], e_din[o]);
    endtask

    task automatic idle();
        phase = 1'b0; full = '0; obf = '0; gnt = '0;
        for (int i = 0; i < 5; i++) q[i] = 64'd0;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        @(posedge clk); #1;
        step(1'b1);
        chk("reset enq", 64'(enq), 64'd0);

        // E input, X hops remaining, U-turn into E output
        idle(); phase = 1'b1;
        full[2] = 1'b1; q[2] = mkpkt(1'b0, 1'b0, 3, 0, 32'hAAAA0001);
        gnt[2] = 5'b00100;
        step(1'b0);
        chk("dir e enq_e", 64'(enq[2]), 64'd1);
        chk("dir e deq_e", 64'(deq[2]), 64'd1);
        chk("dir e d_in_e hx", 64'(d_in[2][55:52]), 64'd2);

        // Same with output buffer full
        obf[2] = 1'b1;
        step(1'b0);
        chk("dir e blocked enq_e", 64'(enq[2]), 64'd0);

        // N input, Y hops, U-turn into N output
        idle(); phase = 1'b1;
        full[4] = 1'b1; q[4] = mkpkt(1'b1, 1'b0, 0, 3, 32'hBBBB0002);
        gnt[4] = 5'b10000;
        step(1'b0);
        chk("dir n enq_n", 64'(enq[4]), 64'd1);
        chk("dir n d_in_n hy", 64'(d_in[4][51:48]), 64'd2);

        // Phase disabled
        phase = 1'b0;
        step(1'b0);
        chk("dir phase0 deq_n", 64'(deq[4]), 64'd0);

        // PE eject, then non-one-hot grant
        idle(); phase = 1'b1;
        full[0] = 1'b1; q[0] = mkpkt(1'b1, 1'b1, 0, 0, 32'hCCCC0003);
        gnt[0] = 5'b00001;
        step(1'b0);
        chk("dir pe d_in_pe", d_in[0], q[0]);
        gnt[0] = 5'b00011;
        step(1'b0);
        gnt[0] = 5'b00000;
        step(1'b0);

        // Grant to a non-requesting input
        gnt[0] = 5'b00100;
        step(1'b0);

        // Reset for 2 cycles with a valid grant present
        gnt[0] = 5'b00001;
        step(1'b1);
        step(1'b1);
        chk("reset mid d_in_pe", d_in[0], 64'd0);
        step(1'b0);

        // Randomized cycles
        for (int c = 0; c < 400; c++) begin
            phase = ($urandom_range(0, 7) != 0);
            for (int i = 0; i < 5; i++) begin
                full[i] = ($urandom_range(0, 3) != 0);
                q[i] = mkpkt(1'($urandom), 1'($urandom),
                             $urandom_range(0, 2), $urandom_range(0, 2), $urandom);
                q[i][63] = 1'($urandom);
                q[i][60:56] = 5'($urandom);
                q[i][47:32] = 16'($urandom);
            end
            for (int o = 0; o < 5; o++) begin
                obf[o] = ($urandom_range(0, 4) == 0);
                if ($urandom_range(0, 2) != 0) begin
                    gnt[o] = '0;
                    for (int i = 0; i < 5; i++)
                        if (full[i] && dest_of(q[i]) == o) gnt[o] = 5'b1 << i;
                end else begin
                    gnt[o] = 5'($urandom);
                end
            end
            step($urandom_range(0, 29) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
